// File: rtl/hbm_rd_arbiter_if.sv
// hbm_rd_arbiter_if -- bundle of AXI read-address / read-data signals for N lanes.
//
// Purpose:
//   One interface type serves both sides of the arbiter.
//   - With N = NUM_REQ it carries the requester-facing bus. Address, length and
//     handshake are per lane. Read data is a single broadcast bus.
//   - With N = 1 it is the shared AXI read master toward HBM.
//
// Parameters:
//   N       number of lanes
//   ADDR_W  read address width
//   DATA_W  read data width (phit size)
//
// Signals (lane i occupies slice i of each vector):
//   araddr  [N*ADDR_W]  burst address
//   arlen   [N*8]       burst length (beats-1)
//   arvalid [N]         address valid
//   arready [N]         address accepted
//   rdata   [DATA_W]    read data (shared by all lanes)
//   rvalid  [N]         beat valid
//   rlast   [N]         last beat of burst
//   rready  [N]         beat ready
//
// Modports:
//   master  issues addresses and consumes data (AXI master side)
//   slave   accepts addresses and produces data (AXI slave side)
interface hbm_rd_arbiter_if #(
  parameter int N      = 1,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 512
);
  logic [N*ADDR_W-1:0] araddr;
  logic [N*8-1:0]      arlen;
  logic [N-1:0]        arvalid;
  logic [N-1:0]        arready;
  logic [DATA_W-1:0]   rdata;
  logic [N-1:0]        rvalid;
  logic [N-1:0]        rlast;
  logic [N-1:0]        rready;

  modport master (
    output araddr, arlen, arvalid, rready,
    input  arready, rdata, rvalid, rlast
  );

  modport slave (
    input  araddr, arlen, arvalid, rready,
    output arready, rdata, rvalid, rlast
  );
endinterface

// File: rtl/hbm_rd_arbiter.sv
// hbm_rd_arbiter -- round-robin arbiter sharing one AXI read master among
// NUM_REQ read requesters, with one outstanding burst at a time.
//
// Ports:
//   ap_clk      clock
//   ap_rst_n    asynchronous active-low reset
//   req         requester-side bus (hbm_rd_arbiter_if.slave, N = NUM_REQ)
//   m_axi       shared HBM read master (hbm_rd_arbiter_if.master, N = 1)
//   busy        high whenever the FSM is outside IDLE
//   stat_beats  running count of accepted read beats; wraps at 2^32
//
// Build option:
//   HBM_RD_ARB_STATS_EN
//     Defined:   the stat_beats counter is built.
//     Undefined: stat_beats is tied to 0.
//
// Flow:
//   IDLE --any arvalid--> ADDR --AR handshake--> DATA --last beat--> IDLE
//
//   The winner is registered on the IDLE->ADDR edge. The search starts at
//   the requester after last_grant. last_grant resets to NUM_REQ-1, so
//   requester 0 has first priority after reset.
module hbm_rd_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 512
) (
  input  logic                ap_clk,
  input  logic                ap_rst_n,
  hbm_rd_arbiter_if.slave     req,
  hbm_rd_arbiter_if.master    m_axi,
  output logic                busy,
  output logic [31:0]         stat_beats
);

  localparam int GRANT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [GRANT_W-1:0] GRANT_RST = GRANT_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [GRANT_W-1:0] grant_reg, grant_next;
  logic [GRANT_W-1:0] last_grant_reg, last_grant_next;

  // Per-requester views of the packed request bus
  logic [ADDR_W-1:0]  addr_slice [NUM_REQ];
  logic [7:0]         len_slice  [NUM_REQ];
  logic [GRANT_W-1:0] rr_dist    [NUM_REQ];
  logic [NUM_REQ-1:0] grant_onehot;
  logic [NUM_REQ-1:0] arready_vec, rvalid_vec, rlast_vec;

  logic               any_req;
  logic [GRANT_W-1:0] rr_winner;
  logic [GRANT_W-1:0] rr_best;
  logic               rr_found;
  logic               sel_rready;
  logic               ar_fire;
  logic               r_fire;
  logic               last_fire;

  // ---------------------------------------------------------------------------
  // Per-requester slicing, priority distance and response demux
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign addr_slice[gi]   = req.araddr[gi*ADDR_W +: ADDR_W];
    assign len_slice[gi]    = req.arlen[gi*8 +: 8];
    assign grant_onehot[gi] = (grant_reg == GRANT_W'(gi));

    // Distance from the first-priority slot (last_grant+1) to requester gi,
    // modulo NUM_REQ. For a power-of-two NUM_REQ, GRANT_W-bit wrap does the
    // modulo for free. Otherwise NUM_REQ fits in GRANT_W bits and the explicit
    // add keeps the result in range.
    if (gi > 0) begin : g_pos
      assign rr_dist[gi] = (GRANT_W'(gi) > last_grant_reg)
                         ? GRANT_W'(gi) - last_grant_reg - GRANT_W'(1)
                         : GRANT_W'(gi) + GRANT_W'(NUM_REQ) - last_grant_reg - GRANT_W'(1);
    end else begin : g_zero
      assign rr_dist[gi] = GRANT_W'(NUM_REQ) - last_grant_reg - GRANT_W'(1);
    end

    assign arready_vec[gi] = (state_reg == ADDR) && grant_onehot[gi] && m_axi.arready;
    assign rvalid_vec[gi]  = (state_reg == DATA) && grant_onehot[gi] && m_axi.rvalid;
    assign rlast_vec[gi]   = (state_reg == DATA) && grant_onehot[gi] && m_axi.rlast;
  end

  assign req.arready = arready_vec;
  assign req.rvalid  = rvalid_vec;
  assign req.rlast   = rlast_vec;

  assign any_req    = |req.arvalid;
  assign sel_rready = req.rready[grant_reg];

  // ---------------------------------------------------------------------------
  // Round-robin pick: the valid requester with the smallest distance
  // ---------------------------------------------------------------------------
  always_comb begin
    rr_winner = last_grant_reg;
    rr_best   = '0;
    rr_found  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req.arvalid[i] && (!rr_found || (rr_dist[i] < rr_best))) begin
        rr_found  = 1'b1;
        rr_best   = rr_dist[i];
        rr_winner = GRANT_W'(i);
      end
    end
  end

  // m_axi.arvalid is 1 throughout ADDR, so the handshake only needs arready.
  assign ar_fire   = (state_reg == ADDR) && m_axi.arready;
  assign r_fire    = (state_reg == DATA) && m_axi.rvalid && sel_rready;
  assign last_fire = r_fire && m_axi.rlast;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_reg      <= IDLE;
      grant_reg      <= GRANT_RST;
      last_grant_reg <= GRANT_RST;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          grant_next = rr_winner;
          state_next = ADDR;
        end
      end
      ADDR: begin
        if (ar_fire) begin
          state_next = DATA;
        end
      end
      DATA: begin
        if (last_fire) begin
          last_grant_next = grant_reg;
          state_next      = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  // Everything is gated by state, so an asynchronous reset (state -> IDLE)
  // zeroes every output at once. This includes rdata while stale beats are
  // still arriving.
  always_comb begin
    m_axi.arvalid = 1'b0;
    m_axi.araddr  = '0;
    m_axi.arlen   = '0;
    m_axi.rready  = 1'b0;
    req.rdata     = '0;
    busy          = 1'b0;
    case (state_reg)
      ADDR: begin
        m_axi.arvalid = 1'b1;
        m_axi.araddr  = addr_slice[grant_reg];
        m_axi.arlen   = len_slice[grant_reg];
        busy          = 1'b1;
      end
      DATA: begin
        m_axi.rready  = sel_rready;
        req.rdata     = m_axi.rdata;
        busy          = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Beat statistics
  // ---------------------------------------------------------------------------
`ifdef HBM_RD_ARB_STATS_EN
  logic [31:0] stat_beats_reg;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      stat_beats_reg <= '0;
    end else if (r_fire) begin
      stat_beats_reg <= stat_beats_reg + 32'd1;
    end
  end

  assign stat_beats = stat_beats_reg;
`else
  assign stat_beats = '0;
`endif

endmodule

// File: tb/tb_hbm_rd_arbiter.sv
// tb_hbm_rd_arbiter -- directed, table-driven bench for hbm_rd_arbiter.
//
// Structure:
//   A table of bursts holds the request pattern and the hand-computed grant,
//   address and length for each burst. Each table entry is run as one full
//   transaction.
//
//   Hand-written sequences then cover three multi-cycle cases:
//   - mid-burst asynchronous reset
//   - R traffic outside DATA
//   - counter wrap
//
// Output: one line is printed per burst.
module tb_hbm_rd_arbiter;

  localparam int NR = 2;
  localparam int AW = 64;
  localparam int DW = 64;

`ifdef HBM_RD_ARB_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        busy;
  logic [31:0] stat_beats;

  hbm_rd_arbiter_if #(.N(NR), .ADDR_W(AW), .DATA_W(DW)) req_if ();
  hbm_rd_arbiter_if #(.N(1),  .ADDR_W(AW), .DATA_W(DW)) m_if ();

  hbm_rd_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .ap_clk     (ap_clk),
    .ap_rst_n   (ap_rst_n),
    .req        (req_if),
    .m_axi      (m_if),
    .busy       (busy),
    .stat_beats (stat_beats)
  );

  always #5 ap_clk = ~ap_clk;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] total_beats = '0;

  typedef struct {
    logic [1:0]  valid;
    logic [63:0] addr0;
    logic [63:0] addr1;
    logic [7:0]  len0;
    logic [7:0]  len1;
    int          exp_grant;
    logic [63:0] exp_addr;
    logic [7:0]  exp_len;
    bit          ar_wait;
    bit          bp;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_stat();
    return STATS_EN ? total_beats : 32'd0;
  endfunction

  // One full transaction:
  //   requests are raised in IDLE
  //   AR must appear exactly one cycle later
  //   exp_len+1 beats are delivered to the owner
  task automatic run_burst(input vec_t v, input int idx);
    logic [1:0]  oh;
    logic [63:0] d;
    int          beats;
    int          cycles;
    bit          rdy;
    oh = 2'b01 << v.exp_grant;
    @(negedge ap_clk);
    m_if.rvalid    = 1'b0;
    m_if.rlast     = 1'b0;
    m_if.arready   = 1'b0;
    req_if.araddr  = {v.addr1, v.addr0};
    req_if.arlen   = {v.len1, v.len0};
    req_if.arvalid = v.valid;
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_arvalid", m_if.arvalid, 0);
    @(posedge ap_clk);
    #1;
    chk("arvalid_latency", m_if.arvalid, 1);
    chk("araddr", m_if.araddr, v.exp_addr);
    chk("arlen", m_if.arlen, v.exp_len);
    chk("addr_busy", busy, 1);
    if (v.ar_wait) begin
      @(negedge ap_clk);
      #1;
      chk("arready_stall", req_if.arready, 2'b00);
      chk("arvalid_hold", m_if.arvalid, 1);
    end
    @(negedge ap_clk);
    m_if.arready = 1'b1;
    #1;
    chk("req_arready", req_if.arready, oh);
    @(posedge ap_clk);
    #1;
    req_if.arvalid[v.exp_grant] = 1'b0;
    beats  = 0;
    cycles = 0;
    while ((beats <= int'(v.exp_len)) && (cycles < 64)) begin
      @(negedge ap_clk);
      cycles++;
      m_if.arready = 1'b0;
      d = {32'hDA7A_0000 + 32'(idx), 32'(beats)};
      m_if.rvalid = 1'b1;
      m_if.rdata  = d;
      m_if.rlast  = (beats == int'(v.exp_len));
      rdy = v.bp ? ((cycles % 2) == 0) : 1'b1;
      req_if.rready = 2'b11;
      req_if.rready[v.exp_grant] = rdy;
      #1;
      chk("data_arvalid", m_if.arvalid, 0);
      chk("req_rvalid", req_if.rvalid, oh);
      chk("req_rlast", req_if.rlast, (beats == int'(v.exp_len)) ? oh : 2'b00);
      chk("req_rdata", req_if.rdata, d);
      chk("m_rready", m_if.rready, rdy);
      @(posedge ap_clk);
      if (rdy) beats++;
    end
    #1;
    req_if.arvalid = '0;
    m_if.rvalid    = 1'b0;
    m_if.rlast     = 1'b0;
    if (cycles >= 64) begin
      failures++;
      $display("FAIL burst_timeout: got %0d beats required %0d", beats, int'(v.exp_len) + 1);
    end
    total_beats = total_beats + 32'(beats);
    chk("busy_after_last", busy, 0);
    chk("stat_beats", stat_beats, exp_stat());
    $display("burst %0d: valid=%b grant=%0d addr=0x%0h len=%0d beats=%0d stat=%0d",
             idx, v.valid, v.exp_grant, v.exp_addr, v.exp_len, beats, stat_beats);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_arvalid"}, m_if.arvalid, 0);
    chk({tag, "_araddr"}, m_if.araddr, 0);
    chk({tag, "_arlen"}, m_if.arlen, 0);
    chk({tag, "_rready"}, m_if.rready, 0);
    chk({tag, "_arready"}, req_if.arready, 0);
    chk({tag, "_rvalid"}, req_if.rvalid, 0);
    chk({tag, "_rlast"}, req_if.rlast, 0);
    chk({tag, "_rdata"}, req_if.rdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_stat"}, stat_beats, 0);
  endtask

  initial begin
    vec_t v;

    // valid  addr0  addr1  len0 len1 grant exp_addr exp_len wait bp
    vecs[0] = '{2'b11, 64'h1000, 64'h8000, 8'd3, 8'd1, 0, 64'h1000, 8'd3, 1'b0, 1'b0};
    vecs[1] = '{2'b11, 64'h1000, 64'h8000, 8'd3, 8'd1, 1, 64'h8000, 8'd1, 1'b1, 1'b0};
    vecs[2] = '{2'b11, 64'h1000, 64'h8000, 8'd3, 8'd1, 0, 64'h1000, 8'd3, 1'b0, 1'b1};
    vecs[3] = '{2'b11, 64'h1000, 64'h8000, 8'd3, 8'd1, 1, 64'h8000, 8'd1, 1'b0, 1'b0};
    vecs[4] = '{2'b01, 64'h1000, 64'h0,    8'd3, 8'd0, 0, 64'h1000, 8'd3, 1'b0, 1'b0};
    vecs[5] = '{2'b10, 64'h0,    64'hABC0, 8'd0, 8'd0, 1, 64'hABC0, 8'd0, 1'b0, 1'b0};
    vecs[6] = '{2'b01, 64'h40,   64'h0,    8'd0, 8'd0, 0, 64'h40,   8'd0, 1'b1, 1'b1};
    vecs[7] = '{2'b01, 64'h2000, 64'h0,    8'd2, 8'd0, 0, 64'h2000, 8'd2, 1'b0, 1'b0};

    req_if.araddr  = '0;
    req_if.arlen   = '0;
    req_if.arvalid = '0;
    req_if.rready  = '0;
    m_if.arready   = 1'b0;
    m_if.rdata     = '0;
    m_if.rvalid    = 1'b0;
    m_if.rlast     = 1'b0;

    // Reset state
    repeat (2) @(negedge ap_clk);
    chk_all_zero("rst");
    ap_rst_n = 1'b1;

    // Table: contention 0,1,0,1, then single-requester and single-beat bursts
    for (int i = 0; i < 8; i++) begin
      run_burst(vecs[i], i);
    end

    // Mid-burst reset: abort during beat 2 of 4. last_grant is 0 before the
    // reset, so a correct reset is the only way req 0 wins the next contention.
    @(negedge ap_clk);
    req_if.araddr  = {64'h9000, 64'h5000};
    req_if.arlen   = {8'd3, 8'd3};
    req_if.arvalid = 2'b01;
    @(posedge ap_clk);
    @(negedge ap_clk);
    m_if.arready = 1'b1;
    @(posedge ap_clk);
    for (int b = 0; b < 2; b++) begin
      @(negedge ap_clk);
      m_if.arready   = 1'b0;
      req_if.arvalid = '0;
      req_if.rready  = 2'b11;
      m_if.rvalid    = 1'b1;
      m_if.rdata     = 64'hBEEF_0000 + 64'(b);
      @(posedge ap_clk);
    end
    total_beats = total_beats + 32'd2;
    @(negedge ap_clk);
    m_if.rdata = 64'hBEEF_0002;
    #1;
    chk("pre_rst_rvalid", req_if.rvalid, 2'b01);
    chk("pre_rst_stat", stat_beats, exp_stat());
    #2;
    ap_rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(negedge ap_clk);
    ap_rst_n    = 1'b1;
    total_beats = '0;
    m_if.rlast  = 1'b1;

    // Stale R beats after reset must be ignored
    for (int c = 0; c < 2; c++) begin
      @(negedge ap_clk);
      #1;
      chk("stale_rvalid", req_if.rvalid, 0);
      chk("stale_rready", m_if.rready, 0);
      chk("stale_busy", busy, 0);
      chk("stale_stat", stat_beats, 0);
    end
    $display("reset: aborted burst at beat 2, stale beats ignored");

    v = '{2'b11, 64'h5000, 64'h9000, 8'd1, 8'd1, 0, 64'h5000, 8'd1, 1'b0, 1'b0};
    run_burst(v, 8);

    // Counter wrap (only meaningful when the counter exists)
    v = '{2'b10, 64'h0, 64'hF000, 8'd0, 8'd0, 1, 64'hF000, 8'd0, 1'b0, 1'b0};
`ifdef HBM_RD_ARB_STATS_EN
    @(negedge ap_clk);
    force dut.stat_beats_reg = 32'hFFFF_FFFF;
    @(negedge ap_clk);
    release dut.stat_beats_reg;
    #1;
    chk("forced_stat", stat_beats, 32'hFFFF_FFFF);
    total_beats = 32'hFFFF_FFFF;
`endif
    run_burst(v, 9);
    chk("wrap_stat", stat_beats, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hbm_rd_arbiter.md
HBM_RD_ARBITER -- requirements
Module: hbm_rd_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 2, giving the number of read requesters (PC/instruction-fetch columns).
REQ-002 The block SHALL have parameter ADDR_W, default 64, giving the AXI read address width.
REQ-003 The block SHALL have parameter DATA_W, default 512, giving the AXI read data width (phit size).
REQ-004 The block SHALL have port ap_clk, input, 1 bit: the single clock.
REQ-005 The block SHALL have port ap_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port req_araddr, input, NUM_REQ*ADDR_W bits: per-requester burst address, requester i in slice i.
REQ-007 The block SHALL have port req_arlen, input, NUM_REQ*8 bits: per-requester AXI burst length (beats-1).
REQ-008 The block SHALL have port req_arvalid, input, NUM_REQ bits: per-requester address valid.
REQ-009 The block SHALL have port req_arready, output, NUM_REQ bits: per-requester address accepted.
REQ-010 The block SHALL have port req_rdata, output, DATA_W bits: read data broadcast to all requesters.
REQ-011 The block SHALL have ports req_rvalid and req_rlast, outputs, NUM_REQ bits each: per-requester beat valid and last beat.
REQ-012 The block SHALL have port req_rready, input, NUM_REQ bits: per-requester beat ready.
REQ-013 The block SHALL have the shared master ports m_axi_araddr (out, ADDR_W), m_axi_arlen (out, 8), m_axi_arvalid (out, 1), m_axi_arready (in, 1), m_axi_rdata (in, DATA_W), m_axi_rvalid (in, 1), m_axi_rlast (in, 1) and m_axi_rready (out, 1).
REQ-014 The block SHALL have port busy, output, 1 bit: set while the FSM is not in IDLE.
REQ-015 The block SHALL have port stat_beats, output, 32 bits: total read beats delivered.

Function
REQ-016 The block SHALL use a three-state FSM with states IDLE, ADDR and DATA, and SHALL allow one outstanding burst at a time.
REQ-017 In IDLE, when any bit of req_arvalid is set, the block SHALL register a round-robin winner, searching from requester (last_grant+1) mod NUM_REQ upward, and SHALL move to ADDR on the next edge.
REQ-018 In ADDR, the block SHALL drive m_axi_arvalid=1, with m_axi_araddr and m_axi_arlen taken combinationally from the granted slice.
REQ-019 In ADDR, req_arready[grant] SHALL equal m_axi_arready, and all other req_arready bits SHALL be 0.
REQ-020 On m_axi_arvalid & m_axi_arready, the block SHALL move to DATA.
REQ-021 Latency: with req_arvalid asserted in IDLE at cycle N, m_axi_arvalid SHALL be asserted at cycle N+1.
REQ-022 In DATA, the block SHALL apply: m_axi_rready = req_rready[grant]; req_rvalid[grant] = m_axi_rvalid; req_rlast[grant] = m_axi_rlast; all non-granted bits 0; req_rdata = m_axi_rdata.
REQ-023 On an accepted beat with m_axi_rlast=1, the block SHALL set last_grant to grant and return to IDLE; the next arbitration SHALL occur no earlier than the following cycle.
REQ-024 Outside DATA, m_axi_rready and all req_rvalid and req_rlast bits SHALL be 0; m_axi_rvalid arriving outside DATA SHALL be ignored.
REQ-025 Simultaneous requests SHALL be served in round-robin order, so no requester waits more than NUM_REQ-1 bursts.
REQ-026 A requester that deasserts arvalid before acceptance violates AXI; the block SHALL hold the grant and issue the request.
REQ-027 stat_beats SHALL increment by 1 on each accepted beat and SHALL wrap from 0xFFFFFFFF to 0.
REQ-028 arlen=0 SHALL be handled as a single-beat burst.

Reset
REQ-029 Asserting ap_rst_n=0 SHALL, asynchronously and at any point including mid-burst, force the FSM to IDLE, set grant and last_grant to NUM_REQ-1 (so requester 0 has first priority), clear stat_beats and drive all outputs to 0.
REQ-030 After reset, the block SHALL not complete an aborted burst; beats still in flight on the R channel SHALL be ignored per REQ-024.

Configuration
REQ-031 With macro HBM_RD_ARB_STATS_EN defined, the block SHALL implement the stat_beats counter.
REQ-032 With HBM_RD_ARB_STATS_EN undefined, the counter SHALL not be implemented, stat_beats SHALL be tied to 0, and all other behaviour SHALL be unchanged.

Verification
REQ-033 Single-requester scenario: req_arvalid=01, addr=0x1000, len=3 -> m_axi_arvalid asserted 1 cycle later with araddr=0x1000 and arlen=3; 4 beats delivered to requester 0 only; busy drops after rlast.
REQ-034 Contention scenario: req_arvalid=11 held for 4 bursts -> grant order 0,1,0,1 and every burst's address matches its owner.
REQ-035 Backpressure scenario: req_rready[grant] toggled every cycle -> m_axi_rready mirrors it, no beat is lost or duplicated, and stat_beats=4 after a len=3 burst.
REQ-036 Reset scenario: ap_rst_n pulsed low during beat 2 of 4 -> all outputs 0 immediately, FSM in IDLE, stat_beats=0, and the next request is granted to requester 0.
REQ-037 Wrap scenario (HBM_RD_ARB_STATS_EN defined, stat_beats forced to 0xFFFFFFFF): one beat accepted -> stat_beats=0; with the macro undefined -> stat_beats stays 0 throughout.
